// File: rtl/cordic_fx2fp_if.sv
// Handshake bundle between the CORDIC core, this float converter and the result bus.
// The master side drives the fixed-point input and takes the result; the slave is the converter.
interface cordic_fx2fp_if #(
   parameter int unsigned W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  result;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  result
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output result
   );
endinterface

// File: rtl/cordic_fx2fp.sv
// Signed fixed-point (Q(W-FRAC).FRAC) to IEEE-754 single converter with one-bit-per-cycle
// normalisation and round-to-nearest-even.
module cordic_fx2fp #(
   parameter int unsigned W    = 32,
   parameter int unsigned FRAC = 30
) (
   input logic           clk,
   input logic           reset,
   input logic           clk_en,
   cordic_fx2fp_if.slave bus
);

   localparam int unsigned SW      = $clog2(W);
   localparam int unsigned EXPBIAS = 127 + W - 1 - FRAC;
   // Selects the bits below the guard bit; empty when W==25.
   localparam logic [W-1:0] STICKYMASK = (W'(1) << (W - 25)) - W'(1);

   typedef enum logic [1:0] {
      StIdle,
      StNorm,
      StRound,
      StDone
   } state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  mag_q, mag_d;
   logic          sign_q, sign_d;
   logic [SW-1:0] s_q, s_d;
   logic [31:0]   result_q, result_d;

   logic [22:0]   mant;
   logic          guard;
   logic          sticky;
   logic          round_up;
   logic [23:0]   mant_rnd;
   logic [7:0]    exp_v;
   logic [31:0]   packed_fp;

   // Rounding datapath, valid while mag_q is normalised (MSB set) or zero.
   always_comb begin
      mant      = mag_q[W-2:W-24];
      guard     = mag_q[W-25];
      sticky    = |(mag_q & STICKYMASK);
      round_up  = guard & (sticky | mant[0]);
      mant_rnd  = {1'b0, mant} + 24'(round_up);
      exp_v     = 8'(EXPBIAS) - 8'(s_q) + 8'(mant_rnd[23]);
      packed_fp = mag_q[W-1] ? {sign_q, exp_v, mant_rnd[22:0]} : 32'h0000_0000;
   end

   always_comb begin
      state_d  = state_q;
      mag_d    = mag_q;
      sign_d   = sign_q;
      s_d      = s_q;
      result_d = result_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               sign_d  = bus.in_data[W-1];
               mag_d   = bus.in_data[W-1] ? (~bus.in_data + W'(1)) : bus.in_data;
               s_d     = '0;
               state_d = (bus.in_data == '0) ? StRound : StNorm;
            end
         end
         StNorm: begin
            if (mag_q[W-1]) begin
               state_d = StRound;
            end else begin
               mag_d = mag_q << 1;
               s_d   = s_q + SW'(1);
            end
         end
         StRound: begin
            result_d = packed_fp;
            state_d  = StDone;
         end
         StDone: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         mag_q    <= '0;
         sign_q   <= 1'b0;
         s_q      <= '0;
         result_q <= '0;
      end else if (clk_en) begin
         state_q  <= state_d;
         mag_q    <= mag_d;
         sign_q   <= sign_d;
         s_q      <= s_d;
         result_q <= result_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.result    = result_q;

endmodule

// File: tb/tb_cordic_fx2fp.sv
// Self-checking bench for cordic_fx2fp (W=32, FRAC=30): directed literal vectors plus a
// randomized run checked every cycle against an arithmetic reference model.
module tb_cordic_fx2fp;

   logic clk = 1'b0;
   logic reset;
   logic clk_en;

   cordic_fx2fp_if #(.W(32)) bus ();

   cordic_fx2fp #(.W(32), .FRAC(30)) dut (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int nchecks = 0;
   int nerrs   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      nchecks++;
      if (act !== req) begin
         nerrs++;
         $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int msb_of(input logic [63:0] m);
      int p = 0;
      for (int i = 0; i < 64; i++) if (m[i]) p = i;
      return p;
   endfunction

   function automatic logic [63:0] mag_of(input logic [31:0] d);
      longint v = longint'($signed(d));
      return (v < 0) ? 64'(-v) : 64'(v);
   endfunction

   // Reference: value = d * 2^-30, rounded to 24 significant bits (RNE) by right shifting.
   function automatic logic [31:0] fp_of(input logic [31:0] d);
      logic [63:0] m, q, rem, half;
      int p, e, sh;
      if (d == 32'h0) return 32'h0;
      m = mag_of(d);
      p = msb_of(m);
      e = p - 30 + 127;
      if (p > 23) begin
         sh   = p - 23;
         q    = m >> sh;
         rem  = m & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 64'd1;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
         end
      end else begin
         q = m << (23 - p);
      end
      return {d[31], e[7:0], q[22:0]};
   endfunction

   // Enabled edges from the accept edge until out_valid is seen.
   function automatic int lat_of(input logic [31:0] d);
      if (d == 32'h0) return 1;
      return (31 - msb_of(mag_of(d))) + 2;
   endfunction

   // Behavioural model: 0 idle, 1 converting (countdown of enabled edges), 2 result held.
   int          m_state = 0;
   int          m_cnt   = 0;
   logic [31:0] m_res   = 32'h0;
   int          n_taken = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_state <= 0;
         m_cnt   <= 0;
      end else if (clk_en) begin
         case (m_state)
            0: if (bus.in_valid) begin
               m_state <= 1;
               m_cnt   <= lat_of(bus.in_data) - 1;
               m_res   <= fp_of(bus.in_data);
            end
            1: begin
               if (m_cnt == 0) m_state <= 2;
               else m_cnt <= m_cnt - 1;
            end
            default: if (bus.out_ready) begin
               m_state <= 0;
               n_taken <= n_taken + 1;
            end
         endcase
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (reset) begin
         check("cyc_in_ready", 32'(bus.in_ready), 32'(m_state == 0));
         check("cyc_out_valid", 32'(bus.out_valid), 32'(m_state == 2));
         if (m_state == 2) check("cyc_result", bus.result, m_res);
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!bus.in_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   // Accept d, optionally stall clk_en for stall_len edges after edge stall_at, then
   // check latency (in all edges) and the result against literals.
   task automatic run_vec(input string name, input logic [31:0] d, input logic [31:0] req,
                          input int lat, input int stall_at, input int stall_len);
      int edges = 0;
      wait_idle();
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      while (!bus.out_valid && edges < 200) begin
         clk_en = !((edges + 1 > stall_at) && (edges + 1 <= stall_at + stall_len));
         @(posedge clk);
         #1;
         edges++;
      end
      clk_en = 1'b1;
      check({name, "_latency"}, 32'(edges), 32'(lat));
      check({name, "_result"}, bus.result, req);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] gen();
      logic [31:0] specials [4] = '{32'h8000_0000, 32'h7fff_ffff, 32'h0000_0001, 32'hffff_ffff};
      case ($urandom_range(0, 4))
         0: return $urandom;
         1: return $urandom >> $urandom_range(0, 31);
         2: return -($urandom >> $urandom_range(0, 31));
         3: return 32'h0;
         default: return specials[$urandom_range(0, 3)];
      endcase
   endfunction

   initial begin
      int n;
      reset         = 1'b0;
      clk_en        = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'h1);
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_result", bus.result, 32'h0);

      check("model_one", fp_of(32'h4000_0000), 32'h3f80_0000);
      check("model_tiny", fp_of(32'h0000_0001), 32'h3080_0000);
      check("model_carry", fp_of(32'h7fff_ffff), 32'h4000_0000);
      check("model_lat_tiny", 32'(lat_of(32'h0000_0001)), 32'd33);

      @(posedge clk);
      #1;
      reset = 1'b1;

      run_vec("t1_pos1", 32'h4000_0000, 32'h3f80_0000, 3, 99, 0);
      run_vec("t1_neg1", 32'hc000_0000, 32'hbf80_0000, 3, 99, 0);
      run_vec("t2_half", 32'h2000_0000, 32'h3f00_0000, 4, 99, 0);
      run_vec("t2_tiny", 32'h0000_0001, 32'h3080_0000, 33, 99, 0);
      run_vec("t2_zero", 32'h0000_0000, 32'h0000_0000, 1, 99, 0);
      run_vec("t3_tie_even", 32'h4000_0040, 32'h3f80_0000, 3, 99, 0);
      run_vec("t3_tie_odd", 32'h4000_00c0, 32'h3f80_0002, 3, 99, 0);
      run_vec("t3_carry", 32'h7fff_ffff, 32'h4000_0000, 3, 99, 0);
      run_vec("t3_neg2", 32'h8000_0000, 32'hc000_0000, 2, 99, 0);

      // Backpressure with a pending input behind the held result.
      wait_idle();
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h2000_0000;
      @(posedge clk);
      #1;
      bus.in_data = 32'h4000_0000;
      n = 0;
      while (!bus.out_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("t4_hold_result", bus.result, 32'h3f00_0000);
         check("t4_hold_in_ready", 32'(bus.in_ready), 32'h0);
         check("t4_hold_out_valid", 32'(bus.out_valid), 32'h1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t4_taken_idle", 32'(bus.in_ready), 32'h1);
      check("t4_taken_out_valid", 32'(bus.out_valid), 32'h0);
      @(posedge clk);
      #1;
      check("t4_new_accept", 32'(bus.in_ready), 32'h0);
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("t4_new_result", bus.result, 32'h3f80_0000);
      @(posedge clk);
      #1;

      run_vec("t5_stall", 32'h0000_0001, 32'h3080_0000, 37, 5, 4);

      // Asynchronous reset in the middle of normalisation.
      wait_idle();
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0000_0001;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("t6_in_ready", 32'(bus.in_ready), 32'h1);
      check("t6_out_valid", 32'(bus.out_valid), 32'h0);
      check("t6_result", bus.result, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      run_vec("t6_after", 32'h2000_0000, 32'h3f00_0000, 4, 99, 0);

      // Randomized traffic; the per-cycle compare process does the checking.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         clk_en        = ($urandom_range(0, 9) != 0);
         bus.in_valid  = $urandom_range(0, 1) == 1;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.in_data   = gen();
      end
      @(negedge clk);
      clk_en        = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      check("rand_enough_results", 32'(n_taken > 100), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
      $finish;
   end

endmodule
